// File: rtl/pooling_pkg.sv
// Shared types and elaboration helpers for the streaming pooling engine.
// No clocked logic; latency and backpressure are defined by the users of this package.
package pooling_pkg;

   typedef enum logic {POOL_MAX = 1'b0, POOL_AVG = 1'b1} pool_mode_e;
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} pool_state_e;

   // Headroom for summing K*K pixels without overflow.
   function automatic int acc_width(input int data_width, input int k);
      return data_width + 2 * $clog2(k);
   endfunction

   function automatic bit kernel_legal(input int k);
      return (k == 2) || (k == 4);
   endfunction

endpackage

// File: rtl/pooling_window_reduce.sv
// Combinational K-to-1 horizontal reduce of one output column: signed max or sign-extended sum.
// Zero latency; no flow control, the caller decides when the result is consumed.
module pooling_window_reduce
   import pooling_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int K          = 2,
   parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, K)
) (
   input  pool_mode_e                    mode,
   input  logic [K*DATA_WIDTH-1:0]       pix_dat,
   output logic signed [ACC_WIDTH-1:0]   red_dat
);

   logic signed [DATA_WIDTH-1:0] px [K];
   logic signed [DATA_WIDTH-1:0] max_v;
   logic signed [ACC_WIDTH-1:0]  sum_v;

   // Pixel 0 sits in the MSBs of the column slice.
   for (genvar i = 0; i < K; i++) begin : g_px
      assign px[i] = pix_dat[(K-1-i)*DATA_WIDTH +: DATA_WIDTH];
   end

   always_comb begin
      max_v = px[0];
      sum_v = '0;
      for (int i = 0; i < K; i++) begin
         if (px[i] > max_v) max_v = px[i];
         sum_v = sum_v + ACC_WIDTH'(px[i]);
      end
      red_dat = (mode == POOL_AVG) ? sum_v : ACC_WIDTH'(max_v);
   end

endmodule

// File: rtl/pooling_stream_engine.sv
// Streaming KxK (stride K) max/average pooling over channel-interleaved rows; result one cycle after the K-th row beat.
// Single-entry output register: in_ready drops while a row is pending and out_ready is low.
module pooling_stream_engine
   import pooling_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int KERNEL_SIZE = 2,
   parameter int IN_WIDTH    = 8,
   parameter int IN_HEIGHT   = 8,
   parameter int CHANNELS    = 4,
   localparam int OUT_WIDTH  = IN_WIDTH / KERNEL_SIZE,
   localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            mode,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [IN_WIDTH*DATA_WIDTH-1:0]  in_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [OUT_WIDTH*DATA_WIDTH-1:0] out_data,
   output logic [CH_W-1:0]                 out_channel,
   output logic                            out_last
);

   localparam int ACC_WIDTH = acc_width(DATA_WIDTH, KERNEL_SIZE);
   localparam int SHIFT     = 2 * $clog2(KERNEL_SIZE);
   localparam int WR_W      = $clog2(KERNEL_SIZE);
   localparam int OUT_H     = IN_HEIGHT / KERNEL_SIZE;
   localparam int OR_W      = (OUT_H > 1) ? $clog2(OUT_H) : 1;
   localparam int KD        = KERNEL_SIZE * DATA_WIDTH;

   localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNELS - 1);
   localparam logic [WR_W-1:0] WR_LAST = WR_W'(KERNEL_SIZE - 1);
   localparam logic [OR_W-1:0] OR_LAST = OR_W'(OUT_H - 1);

   if (!kernel_legal(KERNEL_SIZE)) begin : g_bad_kernel
      $error("pooling_stream_engine: KERNEL_SIZE must be 2 or 4");
   end
   if ((IN_WIDTH % KERNEL_SIZE) != 0 || (IN_HEIGHT % KERNEL_SIZE) != 0) begin : g_bad_dims
      $error("pooling_stream_engine: IN_WIDTH and IN_HEIGHT must be multiples of KERNEL_SIZE");
   end
   if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
      $error("pooling_stream_engine: CHANNELS must be in 1..16");
   end

   pool_state_e state_q, state_d;
   pool_mode_e  mode_q, mode_d, cur_mode;
   logic [CH_W-1:0] ch_cnt_q, ch_cnt_d;
   logic [WR_W-1:0] win_row_q, win_row_d;
   logic [OR_W-1:0] out_row_q, out_row_d;

   logic signed [ACC_WIDTH-1:0] acc_q [CHANNELS][OUT_WIDTH];
   logic signed [ACC_WIDTH-1:0] acc_d [CHANNELS][OUT_WIDTH];

   logic                            out_valid_q, out_valid_d;
   logic [OUT_WIDTH*DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [CH_W-1:0]                 out_channel_q, out_channel_d;
   logic                            out_last_q, out_last_d;

   logic signed [ACC_WIDTH-1:0]  red_v   [OUT_WIDTH];
   logic signed [ACC_WIDTH-1:0]  acc_sel [OUT_WIDTH];
   logic signed [ACC_WIDTH-1:0]  comb_v  [OUT_WIDTH];
   logic signed [DATA_WIDTH-1:0] fin_v   [OUT_WIDTH];

   logic accept;
   logic frame_end;

   assign in_ready  = !rst && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign frame_end = (ch_cnt_q == CH_LAST) && (win_row_q == WR_LAST) && (out_row_q == OR_LAST);

   // The first beat of a frame uses the live mode input; later beats use the latched copy.
   assign cur_mode = (state_q == IDLE) ? pool_mode_e'(mode) : mode_q;

   for (genvar j = 0; j < OUT_WIDTH; j++) begin : g_col
      pooling_window_reduce #(
         .DATA_WIDTH (DATA_WIDTH),
         .K          (KERNEL_SIZE),
         .ACC_WIDTH  (ACC_WIDTH)
      ) u_reduce (
         .mode    (cur_mode),
         .pix_dat (in_data[(OUT_WIDTH-1-j)*KD +: KD]),
         .red_dat (red_v[j])
      );
   end

   always_comb begin
      for (int j = 0; j < OUT_WIDTH; j++) begin
         acc_sel[j] = '0;
         for (int c = 0; c < CHANNELS; c++) begin
            if (c == int'(ch_cnt_q)) acc_sel[j] = acc_q[c][j];
         end
         if (win_row_q == '0)
            comb_v[j] = red_v[j];
         else if (cur_mode == POOL_AVG)
            comb_v[j] = acc_sel[j] + red_v[j];
         else
            comb_v[j] = (red_v[j] > acc_sel[j]) ? red_v[j] : acc_sel[j];
         fin_v[j] = (cur_mode == POOL_AVG) ? DATA_WIDTH'(comb_v[j] >>> SHIFT)
                                           : DATA_WIDTH'(comb_v[j]);
      end
   end

   always_comb begin
      state_d       = state_q;
      mode_d        = mode_q;
      ch_cnt_d      = ch_cnt_q;
      win_row_d     = win_row_q;
      out_row_d     = out_row_q;
      acc_d         = acc_q;
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      out_channel_d = out_channel_q;
      out_last_d    = out_last_q;

      if (out_valid_q && out_ready) out_valid_d = 1'b0;

      if (accept) begin
         if (state_q == IDLE) mode_d = pool_mode_e'(mode);
         if (frame_end)
            state_d = IDLE;
         else if (state_q == IDLE)
            state_d = RUN;

         if (ch_cnt_q == CH_LAST) begin
            ch_cnt_d = '0;
            if (win_row_q == WR_LAST) begin
               win_row_d = '0;
               out_row_d = (out_row_q == OR_LAST) ? '0 : out_row_q + OR_W'(1);
            end else begin
               win_row_d = win_row_q + WR_W'(1);
            end
         end else begin
            ch_cnt_d = ch_cnt_q + CH_W'(1);
         end

         // The K-th row goes straight to the output register; the accumulator slot is rewritten next window.
         if (win_row_q == WR_LAST) begin
            out_valid_d   = 1'b1;
            out_channel_d = ch_cnt_q;
            out_last_d    = frame_end;
            for (int j = 0; j < OUT_WIDTH; j++)
               out_data_d[(OUT_WIDTH-1-j)*DATA_WIDTH +: DATA_WIDTH] = fin_v[j];
         end else begin
            for (int c = 0; c < CHANNELS; c++)
               for (int j = 0; j < OUT_WIDTH; j++)
                  if (c == int'(ch_cnt_q)) acc_d[c][j] = comb_v[j];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         mode_q        <= POOL_MAX;
         ch_cnt_q      <= '0;
         win_row_q     <= '0;
         out_row_q     <= '0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_channel_q <= '0;
         out_last_q    <= 1'b0;
         for (int c = 0; c < CHANNELS; c++)
            for (int j = 0; j < OUT_WIDTH; j++)
               acc_q[c][j] <= '0;
      end else begin
         state_q       <= state_d;
         mode_q        <= mode_d;
         ch_cnt_q      <= ch_cnt_d;
         win_row_q     <= win_row_d;
         out_row_q     <= out_row_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         out_channel_q <= out_channel_d;
         out_last_q    <= out_last_d;
         acc_q         <= acc_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_channel = out_channel_q;
   assign out_last    = out_last_q;

endmodule

// File: tb/tb_pooling_stream_engine.sv
// Directed bench: three engine configurations share one input stream; sel picks whose outputs are checked.
// Vectors are applied one beat per cycle; the backpressure corner is a hand-written sequence.
module tb_pooling_stream_engine;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, mode, in_valid, out_ready;
   logic [127:0] in_data;

   logic        a_rdy, a_vld, a_ch, a_last;
   logic [63:0] a_dat;
   logic        b_rdy, b_vld, b_ch, b_last;
   logic [63:0] b_dat;
   logic        c_rdy, c_vld, c_ch, c_last;
   logic [31:0] c_dat;

   // A: K=2, 4x4, 1 channel.  B: K=2, 4x4, 2 channels.  C: K=4, 4x4, 1 channel.
   pooling_stream_engine #(.DATA_WIDTH(32), .KERNEL_SIZE(2), .IN_WIDTH(4), .IN_HEIGHT(4), .CHANNELS(1)) u_a (
      .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(a_rdy), .in_data(in_data),
      .out_valid(a_vld), .out_ready(out_ready), .out_data(a_dat), .out_channel(a_ch), .out_last(a_last));
   pooling_stream_engine #(.DATA_WIDTH(32), .KERNEL_SIZE(2), .IN_WIDTH(4), .IN_HEIGHT(4), .CHANNELS(2)) u_b (
      .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(b_rdy), .in_data(in_data),
      .out_valid(b_vld), .out_ready(out_ready), .out_data(b_dat), .out_channel(b_ch), .out_last(b_last));
   pooling_stream_engine #(.DATA_WIDTH(32), .KERNEL_SIZE(4), .IN_WIDTH(4), .IN_HEIGHT(4), .CHANNELS(1)) u_c (
      .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(c_rdy), .in_data(in_data),
      .out_valid(c_vld), .out_ready(out_ready), .out_data(c_dat), .out_channel(c_ch), .out_last(c_last));

   int          sel;
   logic        o_rdy, o_vld, o_ch, o_last;
   logic [63:0] o_dat;

   always_comb begin
      o_rdy = a_rdy; o_vld = a_vld; o_dat = a_dat; o_ch = a_ch; o_last = a_last;
      if (sel == 1) begin
         o_rdy = b_rdy; o_vld = b_vld; o_dat = b_dat; o_ch = b_ch; o_last = b_last;
      end else if (sel == 2) begin
         o_rdy = c_rdy; o_vld = c_vld; o_dat = {c_dat, 32'h0}; o_ch = c_ch; o_last = c_last;
      end
   end

   typedef struct {
      bit          rst_b;
      int          sel;
      bit          md;
      logic [31:0] p0, p1, p2, p3;
      bit          ev;
      logic [31:0] e0, e1;
      bit          ech;
      bit          elast;
   } vec_t;

   vec_t tv[$];
   int   n_chk;
   int   n_pass;

   localparam int MINV = 32'sh8000_0000;
   localparam int MAXV = 32'sh7fff_ffff;

   function automatic void add(input bit r, input int s, input bit m, input int p0, input int p1,
                               input int p2, input int p3, input bit ev, input int e0, input int e1,
                               input bit ech, input bit el);
      vec_t v;
      v.rst_b = r; v.sel = s; v.md = m;
      v.p0 = p0; v.p1 = p1; v.p2 = p2; v.p3 = p3;
      v.ev = ev; v.e0 = e0; v.e1 = e1; v.ech = ech; v.elast = el;
      tv.push_back(v);
   endfunction

   function automatic logic [127:0] row(input int a, input int b, input int c, input int d);
      return {32'(a), 32'(b), 32'(c), 32'(d)};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk({tag, " rst in_ready"}, 64'(o_rdy), 64'd0);
      chk({tag, " rst out_valid"}, 64'(o_vld), 64'd0);
      chk({tag, " rst out_data"}, o_dat, 64'd0);
      chk({tag, " rst out_channel"}, 64'(o_ch), 64'd0);
      chk({tag, " rst out_last"}, 64'(o_last), 64'd0);
      rst = 1'b0;
   endtask

   // Called at a falling edge; returns at the next falling edge with in_valid low.
   task automatic beat(input logic [127:0] d, input logic md, input string tag);
      in_data  = d;
      mode     = md;
      in_valid = 1'b1;
      #1 chk({tag, " in_ready"}, 64'(o_rdy), 64'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin
      n_chk = 0; n_pass = 0;
      rst = 1'b1; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0; sel = 0;

      // Max, K=2, one channel, full frame.
      add(1, 0, 0,   1,  5, -3,  2,   0, 0, 0, 0, 0);
      add(0, 0, 0,   4,  0, -1, -7,   1, 5, 2, 0, 0);
      add(0, 0, 0,   9,  9,  9,  9,   0, 0, 0, 0, 0);
      add(0, 0, 0,  -8, -2, -6, -4,   1, 9, 9, 0, 1);
      // Average frame; mode drops to 0 after the first beat and must be ignored.
      add(0, 0, 1,  -1, -2,  3,  3,   0, 0, 0, 0, 0);
      add(0, 0, 0,   0,  0,  3,  2,   1, -1, 2, 0, 0);
      add(0, 0, 0,   0,  0,  0,  0,   0, 0, 0, 0, 0);
      add(0, 0, 0,  -5,  0,  4,  4,   1, -2, 2, 0, 1);
      // Three beats of a frame, then reset and a fresh frame.
      add(0, 0, 0,   1,  5, -3,  2,   0, 0, 0, 0, 0);
      add(0, 0, 0,   4,  0, -1, -7,   1, 5, 2, 0, 0);
      add(0, 0, 0,   9,  9,  9,  9,   0, 0, 0, 0, 0);
      add(1, 0, 0,   2,  3,  4,  5,   0, 0, 0, 0, 0);
      add(0, 0, 0,   1,  1,  1,  1,   1, 3, 5, 0, 0);
      // Two-channel interleave, average.
      add(1, 1, 1,   1,  1,  1,  1,   0, 0, 0, 0, 0);
      add(0, 1, 1,   7,  7,  7,  7,   0, 0, 0, 0, 0);
      add(0, 1, 1,   1,  1,  1,  1,   1, 1, 1, 0, 0);
      add(0, 1, 1,   7,  7,  7,  7,   1, 7, 7, 1, 0);
      add(0, 1, 1,   1,  1,  1,  1,   0, 0, 0, 0, 0);
      add(0, 1, 1,   7,  7,  7,  7,   0, 0, 0, 0, 0);
      add(0, 1, 1,   1,  1,  1,  1,   1, 1, 1, 0, 0);
      add(0, 1, 1,   7,  7,  7,  7,   1, 7, 7, 1, 1);
      // K=4 extremes: max of most-negative, average of most-positive.
      add(1, 2, 0, MINV, MINV, MINV, MINV, 0, 0, 0, 0, 0);
      add(0, 2, 0, MINV, MINV, MINV, MINV, 0, 0, 0, 0, 0);
      add(0, 2, 0, MINV, MINV, MINV, MINV, 0, 0, 0, 0, 0);
      add(0, 2, 0, MINV, MINV, MINV, MINV, 1, MINV, 0, 0, 1);
      add(0, 2, 1, MAXV, MAXV, MAXV, MAXV, 0, 0, 0, 0, 0);
      add(0, 2, 1, MAXV, MAXV, MAXV, MAXV, 0, 0, 0, 0, 0);
      add(0, 2, 1, MAXV, MAXV, MAXV, MAXV, 0, 0, 0, 0, 0);
      add(0, 2, 1, MAXV, MAXV, MAXV, MAXV, 1, MAXV, 0, 0, 1);

      @(negedge clk);
      foreach (tv[i]) begin
         string tag;
         tag = $sformatf("v%0d", i);
         sel = tv[i].sel;
         if (tv[i].rst_b) do_reset(tag);
         beat(row(tv[i].p0, tv[i].p1, tv[i].p2, tv[i].p3), tv[i].md, tag);
         chk({tag, " out_valid"}, 64'(o_vld), 64'(tv[i].ev));
         if (tv[i].ev) begin
            chk({tag, " out_data"}, o_dat, {tv[i].e0, tv[i].e1});
            chk({tag, " out_channel"}, 64'(o_ch), 64'(tv[i].ech));
            chk({tag, " out_last"}, 64'(o_last), 64'(tv[i].elast));
         end
      end

      // Backpressure on the two-channel engine: ch0 result pending, ch1 K-th row waiting.
      sel = 1;
      do_reset("bp");
      beat(row(1, 2, 3, 4), 1'b1, "bp r0c0");
      beat(row(10, 20, 30, 40), 1'b1, "bp r0c1");
      beat(row(5, 6, 7, 8), 1'b1, "bp r1c0");
      chk("bp first out_valid", 64'(o_vld), 64'd1);
      out_ready = 1'b0;
      in_data   = row(10, 20, 30, 40);
      in_valid  = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("bp stall%0d in_ready", k), 64'(o_rdy), 64'd0);
         chk($sformatf("bp stall%0d out_valid", k), 64'(o_vld), 64'd1);
         chk($sformatf("bp stall%0d out_data", k), o_dat, {32'd3, 32'd5});
         @(posedge clk);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1 chk("bp release in_ready", 64'(o_rdy), 64'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp second out_valid", 64'(o_vld), 64'd1);
      chk("bp second out_channel", 64'(o_ch), 64'd1);
      chk("bp second out_data", o_dat, {32'd15, 32'd35});
      chk("bp second out_last", 64'(o_last), 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk("bp drained out_valid", 64'(o_vld), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
